// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the shared-SPI-pin owner arbiter.
// State encoding, pin-mux owner codes and guard counter width.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_OWN_A = 2'd2,
    ST_OWN_B = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_e;

  localparam int GCNT_W = 4;

  function automatic arb_state_e own_state(owner_e o);
    return (o == OWN_B) ? ST_OWN_B : ST_OWN_A;
  endfunction

  function automatic owner_e state_owner(arb_state_e s);
    owner_e o;
    o = OWN_NONE;
    unique case (1'b1)
      (s == ST_OWN_A): o = OWN_A;
      (s == ST_OWN_B): o = OWN_B;
      default:         o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/arb_wait_cnt.sv
// Saturating wait counter for one requester plus its starvation flag.
// Clears whenever the request is withdrawn or the grant is being issued.
import spi_arb_pkg::*;

module arb_wait_cnt #(
  parameter int unsigned STARVE_LIM = 64,
  parameter int unsigned W          = $clog2(STARVE_LIM + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_i,
  input  logic         gnt_i,
  output logic [W-1:0] wait_o,
  output logic         starve_o
);

  localparam logic [W-1:0] LIM = W'(STARVE_LIM);

  logic [W-1:0] wait_q;
  logic [W-1:0] wait_d;

  always_comb begin
    wait_d = wait_q;
    if (!req_i || gnt_i) begin
      wait_d = '0;
    end else if (wait_q != LIM) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign wait_o   = wait_q;
  assign starve_o = (wait_q == LIM);

endmodule

// File: rtl/spi_share_arb.sv
// Owner arbiter for the shared SPI pins: flash core (A) vs LED/button
// sequencer (B), with an idle guard interval on every ownership change.
import spi_arb_pkg::*;

module spi_share_arb #(
  parameter int unsigned GUARD_CYCLES = 2,
  parameter int unsigned STARVE_LIM   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  output logic       gnt_a,
  output logic       yield_a,
  input  logic       req_b,
  output logic       gnt_b,
  output logic [1:0] sel,
  output logic       bus_idle
);

  localparam int unsigned WW = $clog2(STARVE_LIM + 1);

  // From IDLE the arbitration cycle itself is already idle, so one less.
  localparam logic [GCNT_W-1:0] G_IDLE =
    (GUARD_CYCLES == 0) ? '0 : GCNT_W'(GUARD_CYCLES - 1);
  localparam logic [GCNT_W-1:0] G_REL = GCNT_W'(GUARD_CYCLES);

  logic [1:0] rst_sync_q;
  logic       arst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign arst_n = rst_sync_q[1];

  arb_state_e        state_q, state_d;
  owner_e            tgt_q, tgt_d;
  owner_e            win;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              tgt_req;
  logic              starve;
  logic [WW-1:0]     wait_b;

  owner_e sel_d;
  logic   gnt_a_d, gnt_b_d, yield_d, idle_d;
  owner_e sel_q;
  logic   gnt_a_q, gnt_b_q, yield_q, idle_q;

  arb_wait_cnt #(
    .STARVE_LIM (STARVE_LIM),
    .W          (WW)
  ) u_wait (
    .clk      (clk),
    .rst_n    (arst_n),
    .req_i    (req_b),
    .gnt_i    (gnt_b_d),
    .wait_o   (wait_b),
    .starve_o (starve)
  );

  assign tgt_req = (tgt_q == OWN_B) ? req_b : req_a;

  always_comb begin
    win = (starve && req_b) ? OWN_B : (req_a ? OWN_A : OWN_B);
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_a || req_b) begin
          if (GUARD_CYCLES == 0) begin
            state_d = own_state(win);
          end else begin
            state_d = ST_GUARD;
            tgt_d   = win;
            gcnt_d  = G_IDLE;
          end
        end
      end
      ST_GUARD: begin
        if (!tgt_req) begin
          state_d = ST_IDLE;
        end else if (gcnt_q == '0) begin
          state_d = own_state(tgt_q);
        end else begin
          gcnt_d = gcnt_q - 1'b1;
        end
      end
      ST_OWN_A: begin
        if (!req_a) begin
          if (req_b) begin
            state_d = ST_GUARD;
            tgt_d   = OWN_B;
            gcnt_d  = G_REL;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_OWN_B: begin
        if (!req_b) begin
          if (req_a) begin
            state_d = ST_GUARD;
            tgt_d   = OWN_A;
            gcnt_d  = G_REL;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d   = state_owner(state_d);
    gnt_a_d = (state_d == ST_OWN_A);
    gnt_b_d = (state_d == ST_OWN_B);
    idle_d  = (sel_d == OWN_NONE);
    yield_d = (state_q == ST_OWN_A) && starve;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      tgt_q   <= OWN_NONE;
      gcnt_q  <= '0;
      sel_q   <= OWN_NONE;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      yield_q <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      gcnt_q  <= gcnt_d;
      sel_q   <= sel_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      yield_q <= yield_d;
      idle_q  <= idle_d;
    end
  end

  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign yield_a  = yield_q;
  assign sel      = sel_q;
  assign bus_idle = idle_q;

endmodule

// File: tb/tb_spi_share_arb.sv
// Bench for spi_share_arb: directed vector table, GUARD=0 instance
// with random request toggling, and mid-operation reset sequences.
module tb_spi_share_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req_a, req_b, gnt_a, gnt_b, yield_a, bus_idle;
  logic [1:0] sel;
  logic       req_a0, req_b0, gnt_a0, gnt_b0, yield_a0, bus_idle0;
  logic [1:0] sel0;

  spi_share_arb #(.GUARD_CYCLES(2), .STARVE_LIM(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .gnt_a(gnt_a), .yield_a(yield_a),
    .req_b(req_b), .gnt_b(gnt_b),
    .sel(sel), .bus_idle(bus_idle)
  );

  spi_share_arb #(.GUARD_CYCLES(0), .STARVE_LIM(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a0), .gnt_a(gnt_a0), .yield_a(yield_a0),
    .req_b(req_b0), .gnt_b(gnt_b0),
    .sel(sel0), .bus_idle(bus_idle0)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) if (rst_n) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic goto(input int k);
    for (int i = 0; i < 20000 && cyc < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_gnt(input bit on_b, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      seen = on_b ? gnt_b : gnt_a;
    end
    chk(nm, seen, 1);
  endtask

  logic [1:0] psel, psel0;

  always @(negedge clk) begin
    if (!rst_n) begin
      psel  = 2'b00;
      psel0 = 2'b00;
    end else begin
      chk("mutex", gnt_a & gnt_b, 0);
      chk("sel_vs_gnt", sel, {gnt_b, gnt_a});
      chk("bus_idle", bus_idle, ~|sel);
      chk("no_swap", psel != 0 && sel != 0 && sel != psel, 0);
      chk("mutex0", gnt_a0 & gnt_b0, 0);
      chk("sel_vs_gnt0", sel0, {gnt_b0, gnt_a0});
      chk("bus_idle0", bus_idle0, ~|sel0);
      chk("no_swap0", psel0 != 0 && sel0 != 0 && sel0 != psel0, 0);
      psel  = sel;
      psel0 = sel0;
    end
  end

  typedef struct {
    int         k;
    logic       a;
    logic       b;
    logic       ga;
    logic       gb;
    logic [1:0] s;
    logic       y;
  } vec_t;

  vec_t tbl[$];

  initial begin
    req_a = 0; req_b = 0; req_a0 = 0; req_b0 = 0;

    // k: cycle; a/b: reqs driven in that cycle; rest: outputs expected then
    tbl.push_back('{  0, 0, 0, 0, 0, 2'b00, 0});
    tbl.push_back('{ 10, 1, 0, 0, 0, 2'b00, 0});
    tbl.push_back('{ 12, 1, 0, 0, 0, 2'b00, 0});
    tbl.push_back('{ 13, 1, 0, 1, 0, 2'b01, 0});
    tbl.push_back('{ 20, 0, 0, 1, 0, 2'b01, 0});
    tbl.push_back('{ 21, 0, 0, 0, 0, 2'b00, 0});
    tbl.push_back('{ 40, 1, 1, 0, 0, 2'b00, 0});
    tbl.push_back('{ 43, 1, 1, 1, 0, 2'b01, 0});
    tbl.push_back('{ 60, 0, 1, 1, 0, 2'b01, 0});
    tbl.push_back('{ 61, 0, 1, 0, 0, 2'b00, 0});
    tbl.push_back('{ 62, 0, 1, 0, 0, 2'b00, 0});
    tbl.push_back('{ 63, 0, 1, 0, 0, 2'b00, 0});
    tbl.push_back('{ 64, 0, 1, 0, 1, 2'b10, 0});
    tbl.push_back('{ 70, 0, 0, 0, 1, 2'b10, 0});
    tbl.push_back('{ 71, 0, 0, 0, 0, 2'b00, 0});
    tbl.push_back('{ 80, 1, 0, 0, 0, 2'b00, 0});
    tbl.push_back('{ 83, 1, 0, 1, 0, 2'b01, 0});
    tbl.push_back('{ 85, 1, 1, 1, 0, 2'b01, 0});
    tbl.push_back('{149, 1, 1, 1, 0, 2'b01, 0});
    tbl.push_back('{150, 1, 1, 1, 0, 2'b01, 1});
    tbl.push_back('{160, 0, 1, 1, 0, 2'b01, 1});
    tbl.push_back('{161, 1, 1, 0, 0, 2'b00, 1});
    tbl.push_back('{162, 1, 1, 0, 0, 2'b00, 0});
    tbl.push_back('{163, 1, 1, 0, 0, 2'b00, 0});
    tbl.push_back('{164, 1, 1, 0, 1, 2'b10, 0});
    tbl.push_back('{170, 1, 0, 0, 1, 2'b10, 0});
    tbl.push_back('{171, 1, 0, 0, 0, 2'b00, 0});
    tbl.push_back('{174, 1, 0, 1, 0, 2'b01, 0});
    tbl.push_back('{180, 0, 0, 1, 0, 2'b01, 0});
    tbl.push_back('{181, 0, 0, 0, 0, 2'b00, 0});
    tbl.push_back('{200, 0, 1, 0, 0, 2'b00, 0});
    tbl.push_back('{201, 1, 0, 0, 0, 2'b00, 0});
    tbl.push_back('{202, 1, 0, 0, 0, 2'b00, 0});
    tbl.push_back('{204, 1, 0, 0, 0, 2'b00, 0});
    tbl.push_back('{205, 1, 0, 1, 0, 2'b01, 0});
    tbl.push_back('{210, 0, 0, 1, 0, 2'b01, 0});
    tbl.push_back('{211, 0, 0, 0, 0, 2'b00, 0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      goto(tbl[i].k);
      chk($sformatf("row%0d_gnt_a", i), gnt_a, tbl[i].ga);
      chk($sformatf("row%0d_gnt_b", i), gnt_b, tbl[i].gb);
      chk($sformatf("row%0d_sel", i), sel, tbl[i].s);
      chk($sformatf("row%0d_yield", i), yield_a, tbl[i].y);
      chk($sformatf("row%0d_idle", i), bus_idle, tbl[i].s == 2'b00);
      req_a = tbl[i].a;
      req_b = tbl[i].b;
    end

    // zero-guard instance: one-cycle grant latency
    goto(230);
    chk("g0_gnt_b_pre", gnt_b0, 0);
    req_b0 = 1'b1;
    goto(231);
    chk("g0_gnt_b", gnt_b0, 1);
    chk("g0_sel", sel0, 2'b10);
    goto(240);
    req_b0 = 1'b0;
    goto(241);
    chk("g0_release", gnt_b0, 0);

    for (int i = 0; i < 400; i++) begin
      goto(250 + i);
      req_a0 = 1'($urandom_range(0, 1));
      req_b0 = 1'($urandom_range(0, 1));
    end
    req_a0 = 1'b0;
    req_b0 = 1'b0;

    // reset while A owns and B is accumulating wait time
    goto(660);
    req_a = 1'b1;
    wait_gnt(1'b0, "rst1_gnt_a");
    req_b = 1'b1;
    goto(cyc + 6);
    chk("rst1_wait_nonzero", dut.u_wait.wait_q != 0, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst1_gnt_a", gnt_a, 0);
    chk("rst1_sel", sel, 2'b00);
    chk("rst1_idle", bus_idle, 1);
    chk("rst1_yield", yield_a, 0);
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst1_wait_cleared", dut.u_wait.wait_q, 0);

    // reset while B owns the bus
    req_b = 1'b1;
    wait_gnt(1'b1, "rst2_gnt_b");
    goto(cyc + 2);
    #3 rst_n = 1'b0;
    #1;
    chk("rst2_gnt_b", gnt_b, 0);
    chk("rst2_sel", sel, 2'b00);
    chk("rst2_idle", bus_idle, 1);
    req_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst2_wait_cleared", dut.u_wait.wait_q, 0);
    chk("rst2_still_idle", sel, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
